mig_app_arbiter: RTL and testbench

- Shares the single MIG DDR3 user (app) interface between two requesters, e.g. a DMA writer and a frame reader.
- Arbitrates round-robin, drives app_en/app_cmd/app_addr and the write-data FIFO signals, and steers read data back to the issuing requester.
- Read data returns in order; a small tag FIFO records which requester owns each outstanding read.
- Sits in the ui_clk domain between user logic and the MIG wrapper.

---
 rtl/mig_app_pkg.sv | 21 ++
 rtl/mig_tag_fifo.sv | 61 ++++++
 rtl/mig_app_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mig_app_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_app_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_pkg
// Description : Shared constants and types for the MIG app-interface arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mig_app_pkg;

    localparam int ADDR_WIDTH_DEF = 28;
    localparam int DATA_WIDTH_DEF = 128;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mig_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mig_tag_fifo
// Description : 1-bit wide synchronous FIFO recording the owner of each
//               outstanding read. dout is valid combinationally when !empty.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_COUNT);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees a slot this cycle.
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer, occupancy and storage update; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_arbiter
// Description : Round-robin arbiter sharing one MIG DDR3 app interface
//               between two requesters, with in-order read-data steering.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_app_arbiter
    import mig_app_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        calib_done,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_rd,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0] req_mask,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [DATA_WIDTH-1:0]       app_wdf_data,
    output logic [(DATA_WIDTH/8)-1:0]   app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]       app_rd_data,
    input  logic                        app_rd_data_valid,
    output logic                        err_underflow
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic                   r_grant;
    logic                   r_last_grant;
    logic                   r_cmd_pend;
    logic                   r_dat_pend;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [2:0]             r_cmd;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [MASK_WIDTH-1:0]  r_mask;
    logic                   r_err;

    logic [1:0]             w_eligible;
    logic                   w_grant_go;
    logic                   w_grant_id;
    logic                   w_done;
    logic                   w_cmd_pend_next;
    logic                   w_dat_pend_next;
    logic                   w_tag_full;
    logic                   w_tag_empty;
    logic                   w_tag_dout;
    logic                   w_tag_push;
    logic                   w_tag_pop;

    // A read can only be granted while a tag slot is free; writes never wait.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign w_eligible[gi] = req_valid[gi] && calib_done && !(req_rd[gi] && w_tag_full);
    end

    assign app_en        = r_cmd_pend;
    assign app_wdf_wren  = r_dat_pend;
    assign app_wdf_end   = r_dat_pend;
    assign app_addr      = r_addr;
    assign app_cmd       = r_cmd;
    assign app_wdf_data  = r_wdata;
    assign app_wdf_mask  = r_mask;
    assign err_underflow = r_err;
    assign rsp_data      = app_rd_data;

    assign w_tag_push = app_en && app_rdy && (r_cmd == CMD_READ);
    assign w_tag_pop  = app_rd_data_valid && !w_tag_empty;

    mig_tag_fifo #(
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tag_push),
        .pop   (w_tag_pop),
        .din   (r_grant),
        .dout  (w_tag_dout),
        .full  (w_tag_full),
        .empty (w_tag_empty)
    );

    // Next-state, grant selection and completion pulse.
    always_comb begin
        w_state_next    = r_state;
        w_grant_go      = 1'b0;
        w_grant_id      = 1'b0;
        w_done          = 1'b0;
        req_ready       = 2'b00;
        w_cmd_pend_next = r_cmd_pend && !app_rdy;
        w_dat_pend_next = r_dat_pend && !app_wdf_rdy;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_grant_go   = 1'b1;
                    // Both eligible: the one not served last wins.
                    w_grant_id   = (&w_eligible) ? ~r_last_grant : w_eligible[1];
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!w_cmd_pend_next && !w_dat_pend_next) begin
                    w_done             = 1'b1;
                    req_ready[r_grant] = !rst;
                    w_state_next       = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Read data is steered to the owner recorded at the head of the tag FIFO.
    always_comb begin
        rsp_valid = 2'b00;
        if (w_tag_pop && !rst) begin
            rsp_valid[w_tag_dout] = 1'b1;
        end
    end

    // State register and command capture at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd_pend   <= 1'b0;
            r_dat_pend   <= 1'b0;
            r_addr       <= '0;
            r_cmd        <= CMD_WRITE;
            r_wdata      <= '0;
            r_mask       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_go) begin
                r_grant    <= w_grant_id;
                r_addr     <= w_grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                         : req_addr[ADDR_WIDTH-1:0];
                r_cmd      <= req_rd[w_grant_id] ? CMD_READ : CMD_WRITE;
                r_wdata    <= w_grant_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : req_wdata[DATA_WIDTH-1:0];
                r_mask     <= w_grant_id ? req_mask[2*MASK_WIDTH-1:MASK_WIDTH]
                                         : req_mask[MASK_WIDTH-1:0];
                r_cmd_pend <= 1'b1;
                r_dat_pend <= !req_rd[w_grant_id];
            end else begin
                r_cmd_pend <= w_cmd_pend_next;
                r_dat_pend <= w_dat_pend_next;
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Sticky flag: read data arrived with no outstanding read to own it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (app_rd_data_valid && w_tag_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_app_arbiter
// Description : Self-checking bench for mig_app_arbiter: vector table,
//               hand-written corner sequences and randomized traffic against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_app_arbiter;
    import mig_app_pkg::*;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int MW    = 16;
    localparam int DEPTH = 8;

    localparam logic [AW-1:0] A0 = 28'h0000100;
    localparam logic [AW-1:0] A1 = 28'h0000200;
    localparam logic [DW-1:0] D0 = {16{8'hA5}};
    localparam logic [DW-1:0] D1 = {16{8'h5A}};
    localparam logic [MW-1:0] M0 = 16'h0F00;
    localparam logic [MW-1:0] M1 = 16'h00F0;

    logic            clk = 1'b0;
    logic            rst;
    logic            calib_done;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_rd;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*MW-1:0] req_mask;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic            app_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic [MW-1:0]   app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            err_underflow;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mig_app_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_DEPTH   (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .calib_done        (calib_done),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rd            (req_rd),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_mask          (req_mask),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .err_underflow     (err_underflow)
    );

    // One table row: inputs for a cycle and the outputs expected in it.
    typedef struct packed {
        logic [1:0]    vld;
        logic [1:0]    rd;
        logic          ardy;
        logic          wrdy;
        logic          rdv;
        logic          en;
        logic          wren;
        logic [1:0]    rdy;
        logic [1:0]    rsp;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] vld, logic [1:0] rd, logic ardy, logic wrdy,
                                logic rdv, logic en, logic wren, logic [1:0] rdy,
                                logic [1:0] rsp, logic [2:0] cmd, logic [AW-1:0] addr);
        vec_t v;
        v = {vld, rd, ardy, wrdy, rdv, en, wren, rdy, rsp, cmd, addr};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        req_valid         = 2'b00;
        req_rd            = 2'b00;
        app_rd_data_valid = 1'b0;
        app_rdy           = 1'b1;
        app_wdf_rdy       = 1'b1;
        calib_done        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model state (random phase) ----------------
    logic          rq_v  [2];
    logic          rq_rd [2];
    logic [AW-1:0] rq_a  [2];
    logic [DW-1:0] rq_d  [2];
    logic [MW-1:0] rq_m  [2];

    bit            m_busy;
    int            m_owner;
    bit            m_cmd_left;
    bit            m_dat_left;
    bit            m_is_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    int            m_last;
    bit            m_err;
    int            m_tags[$];

    initial begin
        logic [1:0] seen;
        int         acc;
        bit         bad_en;

        rst = 1'b1; calib_done = 1'b1; req_valid = 0; req_rd = 0;
        req_addr = {A1, A0}; req_wdata = {D1, D0}; req_mask = {M1, M0};
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;
        do_reset();

        // ---------------- vector table ----------------
        //                 vld    rd     ar wr rv en wn rdy    rsp    cmd addr
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 1, 1, 0, 1, 1, 2'b01, 2'b00, 0, A0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // command stall: app_rdy low three cycles
        tbl.push_back(mk(2'b01, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 1, 0, 1, 1, 2'b00, 2'b00, 0, A0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, A0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, A0));
        tbl.push_back(mk(2'b01, 2'b00, 1, 1, 0, 1, 0, 2'b01, 2'b00, 0, A0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // data stall: command accepted first, data one cycle later
        tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, A1));
        tbl.push_back(mk(2'b10, 2'b00, 1, 1, 0, 0, 1, 2'b10, 2'b00, 0, A1));
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // read by requester 1 and its data return
        tbl.push_back(mk(2'b10, 2'b10, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b10, 2'b10, 1, 1, 0, 1, 0, 2'b10, 2'b00, 1, A1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        // round robin with both requesters always asking: 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(2'b11, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
            tbl.push_back(mk(2'b11, 2'b00, 1, 1, 0, 1, 1, (k % 2 == 0) ? 2'b01 : 2'b10,
                             2'b00, 0, (k % 2 == 0) ? A0 : A1));
        end
        tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        foreach (tbl[k]) begin
            req_valid = tbl[k].vld; req_rd = tbl[k].rd;
            app_rdy = tbl[k].ardy; app_wdf_rdy = tbl[k].wrdy;
            app_rd_data_valid = tbl[k].rdv; app_rd_data = 128'h1234;
            #2;
            chk($sformatf("tbl%0d_ctl", k),
                {app_en, app_wdf_wren, app_wdf_end, req_ready, rsp_valid, err_underflow},
                {tbl[k].en, tbl[k].wren, tbl[k].wren, tbl[k].rdy, tbl[k].rsp, 1'b0});
            if (tbl[k].en) chk($sformatf("tbl%0d_cmd", k), app_cmd, tbl[k].cmd);
            if (tbl[k].en || tbl[k].wren) chk($sformatf("tbl%0d_addr", k), app_addr, tbl[k].addr);
            if (tbl[k].wren) begin
                chk($sformatf("tbl%0d_wdata", k), app_wdf_data, (tbl[k].addr == A0) ? D0 : D1);
                chk($sformatf("tbl%0d_mask", k), app_wdf_mask, (tbl[k].addr == A0) ? M0 : M1);
            end
            if (tbl[k].rsp != 2'b00) chk($sformatf("tbl%0d_rdata", k), rsp_data, 128'h1234);
            tick();
        end

        // ---------------- tag FIFO full ----------------
        do_reset();
        req_rd = 2'b10; req_valid = 2'b10; acc = 0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            #2;
            if (req_ready[1]) acc++;
            tick();
        end
        chk("tagfull_reads_accepted", acc, DEPTH);
        req_valid = 2'b11; seen = 2'b00; bad_en = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            seen = seen | req_ready;
            if (app_en && app_cmd == CMD_READ) bad_en = 1;
            tick();
            if (seen[0]) req_valid[0] = 1'b0;
        end
        chk("tagfull_write_done", seen[0], 1'b1);
        chk("tagfull_read_blocked", {seen[1], bad_en}, 2'b00);
        app_rd_data_valid = 1; app_rd_data = 128'hBEEF;
        #2;
        chk("tagfull_pop_rsp", {rsp_valid, app_en}, 3'b100);
        chk("tagfull_pop_data", rsp_data, 128'hBEEF);
        tick();
        app_rd_data_valid = 0;
        #2;
        chk("tagfull_grant_cycle", app_en, 1'b0);
        tick();
        #2;
        chk("tagfull_ninth_issue", {app_en, app_cmd, req_ready}, {1'b1, CMD_READ, 2'b10});
        tick();
        req_valid = 2'b00;

        // ---------------- calibration gating and reset ----------------
        calib_done = 0; req_rd = 2'b00; req_valid = 2'b01; bad_en = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (app_en || app_wdf_wren) bad_en = 1;
            tick();
        end
        chk("calib_gate", bad_en, 1'b0);
        calib_done = 1; app_rdy = 0;
        tick();
        #2;
        chk("rst_issue_en", app_en, 1'b1);
        rst = 1;
        tick();
        rst = 0; req_valid = 2'b00; app_rdy = 1; app_rd_data_valid = 1;
        #2;
        chk("rst_en_drop", {app_en, app_wdf_wren}, 2'b00);
        chk("rst_fifo_empty", {rsp_valid, err_underflow}, 3'b000);
        tick();
        app_rd_data_valid = 0;
        #2;
        chk("underflow_set", err_underflow, 1'b1);
        tick();
        #2;
        chk("underflow_sticky", err_underflow, 1'b1);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 0; rq_rd[i] = 0; rq_a[i] = '0; rq_d[i] = '0; rq_m[i] = '0;
        end
        m_busy = 0; m_owner = 0; m_cmd_left = 0; m_dat_left = 0; m_is_rd = 0;
        m_addr = '0; m_data = '0; m_mask = '0; m_last = 1; m_err = 0;
        m_tags.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] e_ready;
            logic [1:0] e_rsp;
            logic [1:0] elig;
            bit         e_en, e_wren, cl_n, dl_n, full_pre;
            int         size_pre;

            for (int i = 0; i < 2; i++) begin
                if (!rq_v[i] && ($urandom % 3 == 0)) begin
                    rq_v[i]  = 1;
                    rq_rd[i] = $urandom % 2;
                    rq_a[i]  = AW'($urandom);
                    rq_d[i]  = {$urandom, $urandom, $urandom, $urandom};
                    rq_m[i]  = MW'($urandom);
                end
            end
            calib_done  = ($urandom % 16 != 0);
            app_rdy     = ($urandom % 4 != 0);
            app_wdf_rdy = ($urandom % 4 != 0);
            size_pre    = m_tags.size();
            app_rd_data_valid = (size_pre > 0) && ($urandom % 3 == 0);
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            req_valid = {rq_v[1], rq_v[0]};
            req_rd    = {rq_rd[1], rq_rd[0]};
            req_addr  = {rq_a[1], rq_a[0]};
            req_wdata = {rq_d[1], rq_d[0]};
            req_mask  = {rq_m[1], rq_m[0]};
            #2;

            e_en    = m_busy && m_cmd_left;
            e_wren  = m_busy && m_dat_left;
            cl_n    = m_cmd_left && !app_rdy;
            dl_n    = m_dat_left && !app_wdf_rdy;
            e_ready = 2'b00;
            if (m_busy && !cl_n && !dl_n) e_ready[m_owner] = 1'b1;
            e_rsp = 2'b00;
            if (app_rd_data_valid && size_pre > 0) e_rsp[m_tags[0]] = 1'b1;

            chk($sformatf("rnd%0d_ctl", cyc),
                {app_en, app_wdf_wren, app_wdf_end, req_ready, rsp_valid, err_underflow},
                {e_en, e_wren, e_wren, e_ready, e_rsp, m_err});
            if (e_en) chk($sformatf("rnd%0d_cmd", cyc), {app_cmd, app_addr},
                          {(m_is_rd ? CMD_READ : CMD_WRITE), m_addr});
            if (e_wren) chk($sformatf("rnd%0d_wr", cyc), {app_wdf_mask, app_wdf_data[111:0]},
                            {m_mask, m_data[111:0]});
            if (e_rsp != 2'b00) chk($sformatf("rnd%0d_rdata", cyc), rsp_data, app_rd_data);

            // advance the model to the next cycle
            if (app_rd_data_valid) begin
                if (size_pre > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (e_en && app_rdy && m_is_rd) m_tags.push_back(m_owner);
            full_pre = (size_pre >= DEPTH);
            if (m_busy) begin
                if (e_ready != 2'b00) begin
                    m_busy = 0;
                    m_last = m_owner;
                    rq_v[m_owner] = 0;
                end else begin
                    m_cmd_left = cl_n;
                    m_dat_left = dl_n;
                end
            end else begin
                for (int i = 0; i < 2; i++)
                    elig[i] = rq_v[i] && calib_done && !(rq_rd[i] && full_pre);
                if (elig != 2'b00) begin
                    if (elig == 2'b11) m_owner = 1 - m_last;
                    else m_owner = elig[1] ? 1 : 0;
                    m_busy     = 1;
                    m_is_rd    = rq_rd[m_owner];
                    m_cmd_left = 1;
                    m_dat_left = !rq_rd[m_owner];
                    m_addr     = rq_a[m_owner];
                    m_data     = rq_d[m_owner];
                    m_mask     = rq_m[m_owner];
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
